// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: write-side master for the 32x32 register file.
// Buffers writeback results in a DEPTH-entry FIFO and drains one entry per
// cycle onto the registered file write port (oWrite/oAddrC/oRegC). Two
// combinational forwarding ports report the newest pending value for a
// register that has not yet been committed. Writes to x0 are accepted and dropped.
//
// Ports:
//   iClk, nRst            clock (rising edge), asynchronous active-low reset
//   iValid/oReady         writeback request handshake (oReady = count < DEPTH)
//   iAddr, iData          writeback destination register and value
//   iStall                hold queue head, no drain this cycle
//   oWrite/oAddrC/oRegC   registered register-file write port
//   iLookA/oHitA/oFwdA    forwarding lookup port A (combinational)
//   iLookB/oHitB/oFwdB    forwarding lookup port B (combinational)
//   oCount                entries queued, excluding the output stage
module rf_writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       iClk,
    input  logic                       nRst,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [ADDR_W-1:0]          iAddr,
    input  logic [DATA_W-1:0]          iData,
    input  logic                       iStall,
    output logic                       oWrite,
    output logic [ADDR_W-1:0]          oAddrC,
    output logic [DATA_W-1:0]          oRegC,
    input  logic [ADDR_W-1:0]          iLookA,
    output logic                       oHitA,
    output logic [DATA_W-1:0]          oFwdA,
    input  logic [ADDR_W-1:0]          iLookB,
    output logic                       oHitB,
    output logic [DATA_W-1:0]          oFwdB,
    output logic [$clog2(DEPTH+1)-1:0] oCount
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr_c;
    logic [DATA_W-1:0] r_reg_c;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    // Ready looks only at the registered count; a same-cycle pop does not free a slot.
    assign w_ready = (r_count < CNT_W'(DEPTH));
    // x0 requests complete the handshake but never occupy an entry.
    assign w_push  = iValid && w_ready && (iAddr != '0);
    assign w_pop   = (r_count != '0) && !iStall;

    // Queue control and registered write port.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_write  <= 1'b0;
            r_addr_c <= '0;
            r_reg_c  <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_write  <= w_pop;
            r_addr_c <= w_pop ? r_addr[r_rd_ptr] : '0;
            r_reg_c  <= w_pop ? r_data[r_rd_ptr] : '0;
        end
    end

    // Entry payload storage; validity is tracked by r_vld.
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= iAddr;
            r_data[r_wr_ptr] <= iData;
        end
    end

    // Forwarding: scan oldest to newest so later matches override earlier ones;
    // the output stage is older than every queued entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        w_hit_a = 1'b0;
        w_fwd_a = '0;
        w_hit_b = 1'b0;
        w_fwd_b = '0;
        if (r_write && (r_addr_c == iLookA)) begin
            w_hit_a = 1'b1;
            w_fwd_a = r_reg_c;
        end
        if (r_write && (r_addr_c == iLookB)) begin
            w_hit_b = 1'b1;
            w_fwd_b = r_reg_c;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr + PTR_W'(k);
            if (r_vld[idx] && (r_addr[idx] == iLookA)) begin
                w_hit_a = 1'b1;
                w_fwd_a = r_data[idx];
            end
            if (r_vld[idx] && (r_addr[idx] == iLookB)) begin
                w_hit_b = 1'b1;
                w_fwd_b = r_data[idx];
            end
        end
        if (iLookA == '0) begin
            w_hit_a = 1'b0;
            w_fwd_a = '0;
        end
        if (iLookB == '0) begin
            w_hit_b = 1'b0;
            w_fwd_b = '0;
        end
    end

    assign oReady = w_ready;
    assign oWrite = r_write;
    assign oAddrC = r_addr_c;
    assign oRegC  = r_reg_c;
    assign oHitA  = w_hit_a;
    assign oFwdA  = w_fwd_a;
    assign oHitB  = w_hit_b;
    assign oFwdB  = w_fwd_b;
    assign oCount = r_count;

endmodule
